// File: rtl/pc_fetch_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface pc_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/pc_fetch.sv
// Program-counter and instruction-fetch unit: FETCH/EXEC/ERR sequencer with
// jr/jump/branch redirect selection and a bounded wait for the memory ack.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_addr_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jr_i,
  input  logic [31:0] jr_addr_i,
  input  logic        stall_i,
  pc_fetch_if.master  imem,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus_4_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_err_o
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [31:0]      pc_plus_4;
  logic [31:0]      next_pc;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] select_target(
    input logic        jr,
    input logic [31:0] jr_addr,
    input logic        jump,
    input logic [25:0] jump_index,
    input logic        branch,
    input logic [31:0] branch_addr,
    input logic [31:0] seq_pc
  );
    logic [31:0] t;
    if (jr)          t = jr_addr;
    else if (jump)   t = {seq_pc[31:28], jump_index, 2'b00};
    else if (branch) t = branch_addr;
    else             t = seq_pc;
    return word_align(t);
  endfunction

  assign pc_plus_4 = pc_q + 32'd4;
  assign next_pc   = select_target(jr_i, jr_addr_i, jump_i, jump_index_i,
                                   branch_taken_i, branch_addr_i, pc_plus_4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_FETCH: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem.ack) begin
          inst_d  = imem.rdata;
          cnt_d   = '0;
          state_d = S_EXEC;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_EXEC: begin
        if (!stall_i) begin
          pc_d    = next_pc;
          state_d = S_FETCH;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  assign imem.req     = (state_q == S_FETCH);
  assign imem.addr    = pc_q;
  assign pc_o         = pc_q;
  assign pc_plus_4_o  = pc_plus_4;
  assign inst_o       = inst_q;
  assign inst_valid_o = (state_q == S_EXEC);
  assign fetch_err_o  = err_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequential fetch, redirect priority, stall,
// timeout, ack at the wait limit, address boundaries and asynchronous reset.
module tb_pc_fetch;
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        clk;
  logic        rst_n;
  logic        branch_taken, jump, jr, stall;
  logic [31:0] branch_addr, jr_addr;
  logic [25:0] jump_index;
  logic [31:0] pc, pc_plus_4, inst;
  logic        inst_valid, fetch_err;
  logic        auto_ack, manual_ack;
  logic [31:0] manual_rdata;
  int          nvec, nerr;

  pc_fetch_if imem ();

  assign imem.ack   = auto_ack ? imem.req : manual_ack;
  assign imem.rdata = auto_ack ? (imem.addr ^ K) : manual_rdata;

  pc_fetch #(.RESET_PC(32'h0000_0000), .MAX_WAIT(15)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .branch_taken_i (branch_taken),
    .branch_addr_i  (branch_addr),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .jr_i           (jr),
    .jr_addr_i      (jr_addr),
    .stall_i        (stall),
    .imem           (imem.master),
    .pc_o           (pc),
    .pc_plus_4_o    (pc_plus_4),
    .inst_o         (inst),
    .inst_valid_o   (inst_valid),
    .fetch_err_o    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starting in EXEC, redirect through jr and return in EXEC at addr.
  task automatic go_to(input logic [31:0] addr);
    jr = 1'b1; jr_addr = addr;
    tick();
    jr = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    nvec++; if (inst !== 32'h0) begin nerr++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0); end
    nvec++; if (imem.req !== 1'b1) begin nerr++; $display("FAIL reset_req: got %b want 1", imem.req); end
    nvec++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
    nvec++; if (fetch_err !== 1'b0) begin nerr++; $display("FAIL reset_err: got %b want 0", fetch_err); end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    tick();
    for (int k = 0; k < 4; k++) begin
      exp_pc = 32'(4 * k);
      nvec++; if (pc !== exp_pc) begin nerr++; $display("FAIL seq_pc: got %h want %h", pc, exp_pc); end
      nvec++; if (inst !== (exp_pc ^ K)) begin nerr++; $display("FAIL seq_inst: got %h want %h", inst, exp_pc ^ K); end
      nvec++; if (inst_valid !== 1'b1) begin nerr++; $display("FAIL seq_valid_hi: got %b want 1", inst_valid); end
      nvec++; if (imem.req !== 1'b0) begin nerr++; $display("FAIL seq_req_lo: got %b want 0", imem.req); end
      if (k == 3) break;
      tick();
      nvec++; if (inst_valid !== 1'b0) begin nerr++; $display("FAIL seq_valid_lo: got %b want 0", inst_valid); end
      nvec++; if (imem.addr !== exp_pc + 32'd4) begin nerr++; $display("FAIL seq_addr: got %h want %h", imem.addr, exp_pc + 32'd4); end
      tick();
    end
  endtask

  task automatic test_priority();
    go_to(32'h100);
    jr = 1'b1; jr_addr = 32'h2000; jump = 1'b1; jump_index = 26'h40;
    branch_taken = 1'b1; branch_addr = 32'h300;
    nvec++; if (pc_plus_4 !== 32'h104) begin nerr++; $display("FAIL prio_pc4: got %h want %h", pc_plus_4, 32'h104); end
    tick();
    nvec++; if (pc !== 32'h2000) begin nerr++; $display("FAIL prio_jr: got %h want %h", pc, 32'h2000); end
    // redirects and stall while in FETCH must be ignored
    jump = 1'b0; branch_taken = 1'b0; jr_addr = 32'h5000; stall = 1'b1;
    tick();
    nvec++; if (pc !== 32'h2000) begin nerr++; $display("FAIL prio_fetch_ignore: got %h want %h", pc, 32'h2000); end
    nvec++; if (inst !== (32'h2000 ^ K)) begin nerr++; $display("FAIL prio_fetch_inst: got %h want %h", inst, 32'h2000 ^ K); end
    jr = 1'b0; stall = 1'b0;
    go_to(32'h100);
    jump = 1'b1; jump_index = 26'h40; branch_taken = 1'b1; branch_addr = 32'h300;
    tick();
    nvec++; if (pc !== 32'h100) begin nerr++; $display("FAIL prio_jump: got %h want %h", pc, 32'h100); end
    jump = 1'b0; branch_taken = 1'b0;
    tick();
    branch_taken = 1'b1;
    tick();
    nvec++; if (pc !== 32'h300) begin nerr++; $display("FAIL prio_branch: got %h want %h", pc, 32'h300); end
    branch_taken = 1'b0;
    tick();
    go_to(32'h7000_0010);
    jump = 1'b1; jump_index = 26'h3FF_FFFF;
    tick();
    nvec++; if (pc !== 32'h7FFF_FFFC) begin nerr++; $display("FAIL prio_jump_upper: got %h want %h", pc, 32'h7FFF_FFFC); end
    jump = 1'b0;
    tick();
    go_to(32'h300);
  endtask

  task automatic test_stall();
    branch_taken = 1'b1; branch_addr = 32'h480; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      nvec++; if (pc !== 32'h300) begin nerr++; $display("FAIL stall_pc: got %h want %h", pc, 32'h300); end
      nvec++; if (inst !== (32'h300 ^ K)) begin nerr++; $display("FAIL stall_inst: got %h want %h", inst, 32'h300 ^ K); end
      nvec++; if (imem.req !== 1'b0) begin nerr++; $display("FAIL stall_req: got %b want 0", imem.req); end
    end
    stall = 1'b0;
    tick();
    nvec++; if (pc !== 32'h480) begin nerr++; $display("FAIL stall_release: got %h want %h", pc, 32'h480); end
    branch_taken = 1'b0;
    tick();
  endtask

  task automatic test_boundary();
    go_to(32'hFFFF_FFFC);
    nvec++; if (pc_plus_4 !== 32'h0) begin nerr++; $display("FAIL bnd_pc4_wrap: got %h want %h", pc_plus_4, 32'h0); end
    tick();
    nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL bnd_seq_wrap: got %h want %h", pc, 32'h0); end
    tick();
    jr = 1'b1; jr_addr = 32'h1003;
    tick();
    nvec++; if (pc !== 32'h1000) begin nerr++; $display("FAIL bnd_jr_align: got %h want %h", pc, 32'h1000); end
    jr = 1'b0;
    tick();
    branch_taken = 1'b1; branch_addr = 32'h2002;
    tick();
    nvec++; if (pc !== 32'h2000) begin nerr++; $display("FAIL bnd_br_align: got %h want %h", pc, 32'h2000); end
    branch_taken = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    go_to(32'h40);
    #3 rst_n = 1'b0;
    #1;
    nvec++; if (pc !== 32'h0) begin nerr++; $display("FAIL areset_pc: got %h want %h", pc, 32'h0); end
    nvec++; if (imem.req !== 1'b1) begin nerr++; $display("FAIL areset_req: got %b want 1", imem.req); end
    nvec++; if (inst !== 32'h0) begin nerr++; $display("FAIL areset_inst: got %h want %h", inst, 32'h0); end
    #1 rst_n = 1'b1;
    tick();
    nvec++; if (inst !== K) begin nerr++; $display("FAIL areset_first_fetch: got %h want %h", inst, K); end
  endtask

  task automatic test_timeout();
    auto_ack = 1'b0; manual_ack = 1'b0;
    tick();
    for (int i = 1; i < 15; i++) begin
      tick();
      nvec++; if (fetch_err !== 1'b0 || imem.req !== 1'b1) begin
        nerr++; $display("FAIL to_waiting cycle %0d: err=%b req=%b want err=0 req=1", i, fetch_err, imem.req);
      end
    end
    tick();
    nvec++; if (fetch_err !== 1'b1) begin nerr++; $display("FAIL to_err: got %b want 1", fetch_err); end
    nvec++; if (imem.req !== 1'b0) begin nerr++; $display("FAIL to_req: got %b want 0", imem.req); end
    manual_ack = 1'b1; manual_rdata = 32'hDEAD_BEEF; jr = 1'b1; jr_addr = 32'h900;
    tick(); tick();
    nvec++; if (inst !== K) begin nerr++; $display("FAIL to_late_ack_inst: got %h want %h", inst, K); end
    nvec++; if (pc !== 32'h4) begin nerr++; $display("FAIL to_pc_held: got %h want %h", pc, 32'h4); end
    nvec++; if (inst_valid !== 1'b0 || fetch_err !== 1'b1) begin
      nerr++; $display("FAIL to_terminal: valid=%b err=%b want valid=0 err=1", inst_valid, fetch_err);
    end
    manual_ack = 1'b0; jr = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    nvec++; if (fetch_err !== 1'b0) begin nerr++; $display("FAIL to_reset_err: got %b want 0", fetch_err); end
    nvec++; if (pc !== 32'h0 || imem.req !== 1'b1) begin
      nerr++; $display("FAIL to_reset_state: pc=%h req=%b want pc=0 req=1", pc, imem.req);
    end
  endtask

  task automatic test_ack_at_limit();
    #1 rst_n = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    manual_ack = 1'b1; manual_rdata = 32'hDEAD_BEEF;
    tick();
    nvec++; if (inst_valid !== 1'b1 || fetch_err !== 1'b0) begin
      nerr++; $display("FAIL lim_success: valid=%b err=%b want valid=1 err=0", inst_valid, fetch_err);
    end
    nvec++; if (inst !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lim_inst: got %h want %h", inst, 32'hDEAD_BEEF); end
    stall = 1'b1; manual_rdata = 32'h1234_5678;
    tick();
    nvec++; if (inst !== 32'hDEAD_BEEF) begin nerr++; $display("FAIL lim_exec_ack_ignored: got %h want %h", inst, 32'hDEAD_BEEF); end
    stall = 1'b0; manual_ack = 1'b0;
    tick();
    nvec++; if (pc !== 32'h4 || imem.req !== 1'b1) begin
      nerr++; $display("FAIL lim_next_fetch: pc=%h req=%b want pc=4 req=1", pc, imem.req);
    end
  endtask

  initial begin
    nvec = 0; nerr = 0;
    rst_n = 1'b0; auto_ack = 1'b1; manual_ack = 1'b0; manual_rdata = 32'h0;
    branch_taken = 1'b0; branch_addr = 32'h0; jump = 1'b0; jump_index = 26'h0;
    jr = 1'b0; jr_addr = 32'h0; stall = 1'b0;
    test_reset();
    test_sequential();
    test_priority();
    test_stall();
    test_boundary();
    test_async_reset();
    test_timeout();
    test_ack_at_limit();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
